tbcm_demux: RTL

- Stream demultiplexer: routes one valid/ready input stream to one of ENTRIES output streams, chosen by a one-hot or binary select.
- Counterpart of the tbcm mux (which collapses N sources to one); the demux fans one source out to N sinks.
- One registered output stage gives full throughput with ready back-pressure.
- Optional packet mode locks the destination from the first beat until the last beat of a packet.

---
 rtl/tbcm_pkg.sv | 27 ++
 rtl/tbcm_demux_slice.sv | 51 +++++
 rtl/tbcm_demux.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tbcm_pkg.sv
// tbcm_pkg: definitions shared by the tbcm stream mux and demux.
//   tbcm_onehot_to_index : OR-encodes a one-hot (or multi-hot) select into an index.
//   lock_state_e         : packet lock state (IDLE / LOCKED).
package tbcm_pkg;

    // Widest one-hot select the shared decoder accepts.
    localparam int TBCM_MAX_ENTRIES = 64;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

    // Bit i of the result is the OR over j of (select[j] & j[i]).
    // A zero select maps to index 0; a multi-hot select maps to the OR of its indices.
    function automatic logic [31:0] tbcm_onehot_to_index(input logic [TBCM_MAX_ENTRIES-1:0] select);
        logic [31:0] index;
        index = '0;
        for (int j = 0; j < TBCM_MAX_ENTRIES; j++) begin
            if (select[j]) begin
                index = index | 32'(j);
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/tbcm_demux_slice.sv
// tbcm_demux_slice: one-entry valid/ready register carrying payload, last flag
// and destination index. Loads a new beat on the same edge the held beat leaves.
//   clk, rst     : clock, synchronous active-high reset (clears valid only)
//   push         : load a beat this cycle (only honoured while ready)
//   push_index   : destination index of the pushed beat
//   push_data    : payload of the pushed beat
//   push_last    : last flag of the pushed beat
//   pop          : the held beat's destination is ready
//   ready        : register can take a beat this cycle
//   valid        : a beat is held
//   index/data/last : the held beat
module tbcm_demux_slice #(
    parameter type DATA_TYPE   = logic [1:0],
    parameter int  INDEX_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [INDEX_WIDTH-1:0] push_index,
    input  DATA_TYPE               push_data,
    input  logic                   push_last,
    input  logic                   pop,
    output logic                   ready,
    output logic                   valid,
    output logic [INDEX_WIDTH-1:0] index,
    output DATA_TYPE               data,
    output logic                   last
);

    assign ready = !valid || pop;

    // When ready, valid follows push: an accepted-but-not-loaded beat
    // lets the register empty if the held beat is consumed on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= push;
        end
    end

    // Payload is not reset; it is don't-care while valid is low.
    always_ff @(posedge clk) begin
        if (ready && push) begin
            index <= push_index;
            data  <= push_data;
            last  <= push_last;
        end
    end

endmodule

// File: rtl/tbcm_demux.sv
// tbcm_demux: routes one valid/ready stream to one of ENTRIES output streams.
// One registered output stage (1-cycle latency, full throughput). Optional
// packet mode locks the destination from the first beat to the i_last beat.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_select       : destination select (one-hot or binary), qualified by i_valid
//   i_valid/o_ready: input handshake
//   i_data, i_last : input payload and end-of-packet flag
//   o_valid/i_ready: per-destination handshake
//   o_data, o_last : per-destination payload (shared register) and last flag
//   o_drop         : one-cycle pulse after an accepted beat with an invalid binary index
module tbcm_demux
    import tbcm_pkg::*;
#(
    parameter int  WIDTH       = 2,
    parameter type DATA_TYPE   = logic [WIDTH-1:0],
    parameter int  ENTRIES     = 2,
    parameter bit  ONE_HOT     = 1'b1,
    parameter bit  PACKET_MODE = 1'b0,
    localparam int INDEX_WIDTH  = $clog2(ENTRIES),
    localparam int SELECT_WIDTH = ONE_HOT ? ENTRIES : INDEX_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [SELECT_WIDTH-1:0] i_select,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  DATA_TYPE                i_data,
    input  logic                    i_last,
    output logic [ENTRIES-1:0]      o_valid,
    input  logic [ENTRIES-1:0]      i_ready,
    output DATA_TYPE                o_data [ENTRIES],
    output logic [ENTRIES-1:0]      o_last,
    output logic                    o_drop
);

    logic [31:0]            select_full;
    logic [INDEX_WIDTH-1:0] select_index;
    logic                   select_ok;
    logic [INDEX_WIDTH-1:0] route_index;
    logic                   route_ok;
    logic                   accept;
    logic                   push;
    logic                   dest_ready;
    logic                   valid_q;
    logic [INDEX_WIDTH-1:0] index_q;
    DATA_TYPE               data_q;
    logic                   last_q;
    logic                   drop_q;

    // ---------------- select decode ----------------
    always_comb begin
        select_full = '0;
        select_ok   = 1'b1;
        if (ONE_HOT) begin
            select_full = tbcm_onehot_to_index(TBCM_MAX_ENTRIES'(i_select));
        end else begin
            select_full = 32'(i_select);
            select_ok   = select_full < 32'(ENTRIES);
        end
    end

    assign select_index = select_full[INDEX_WIDTH-1:0];

    // ---------------- destination lock ----------------
    generate
        if (PACKET_MODE) begin : g_lock
            lock_state_e            state_q;
            logic [INDEX_WIDTH-1:0] lock_index_q;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    state_q <= LOCK_IDLE;
                end else if (accept) begin
                    case (state_q)
                        LOCK_IDLE: begin
                            // A dropped first beat latches nothing, so the
                            // rest of that packet is re-decoded (and dropped).
                            if (select_ok && !i_last) begin
                                state_q      <= LOCK_LOCKED;
                                lock_index_q <= select_index;
                            end
                        end
                        LOCK_LOCKED: begin
                            if (i_last) begin
                                state_q <= LOCK_IDLE;
                            end
                        end
                        default: state_q <= LOCK_IDLE;
                    endcase
                end
            end

            always_comb begin
                route_index = select_index;
                route_ok    = select_ok;
                if (state_q == LOCK_LOCKED) begin
                    route_index = lock_index_q;
                    route_ok    = 1'b1;
                end
            end
        end else begin : g_nolock
            assign route_index = select_index;
            assign route_ok    = select_ok;
        end
    endgenerate

    // ---------------- handshake and output register ----------------
    // A held index can only be out of range for a multi-hot select with a
    // non-power-of-two ENTRIES; it has no sink, so let it drain.
    always_comb begin
        dest_ready = 1'b1;
        if (32'(index_q) < 32'(ENTRIES)) begin
            dest_ready = i_ready[index_q];
        end
    end

    assign accept = i_valid && o_ready;
    assign push   = accept && route_ok;

    tbcm_demux_slice #(
        .DATA_TYPE   (DATA_TYPE),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_slice (
        .clk        (i_clk),
        .rst        (i_rst),
        .push       (push),
        .push_index (route_index),
        .push_data  (i_data),
        .push_last  (i_last),
        .pop        (dest_ready),
        .ready      (o_ready),
        .valid      (valid_q),
        .index      (index_q),
        .data       (data_q),
        .last       (last_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= accept && !route_ok;
        end
    end

    assign o_drop = drop_q;

    generate
        for (genvar k = 0; k < ENTRIES; k++) begin : g_out
            assign o_valid[k] = valid_q && (index_q == INDEX_WIDTH'(k));
            assign o_last[k]  = o_valid[k] && last_q;
            assign o_data[k]  = data_q;
        end
    endgenerate

endmodule
